mem_access_unit: RTL
====================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: address width.
REQ-002 Parameter DATA_WIDTH, default 32: data width; byte lanes = DATA_WIDTH/8 = 4.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  reset; asynchronous, active-low.
REQ-005 mem_read_flag, mem_write_flag, mem_sign_ext_flag  in  1 each  access type and load extension, from EX/MEM register.
REQ-006 mem_sel  in  4  byte-lane select.
REQ-007 mem_write_data  in  DATA_WIDTH  store data, right-justified.
REQ-008 result_in  in  DATA_WIDTH  ALU result; byte address when an access is present.
REQ-009 reg_write_en_in, reg_write_addr_in[4:0], current_pc_addr_in[ADDR_WIDTH]  in  forwarded to WB.
REQ-010 stall_next_stage  in  1  MEM/WB cannot accept this cycle.
REQ-011 ram_req  out  1  bus request.
REQ-012 ram_we  out  4  per-lane write strobes; all zero for reads.
REQ-013 ram_addr  out  ADDR_WIDTH  word-aligned address {result_in[31:2],2'b00}.
REQ-014 ram_wdata  out  DATA_WIDTH  lane-replicated store data.
REQ-015 ram_ack  in  1  bus accept/complete; ram_rdata valid in same cycle for reads.
REQ-016 ram_rdata  in  DATA_WIDTH  read data.
REQ-017 stall_request  out  1  holds EX/MEM and earlier stages.
REQ-018 align_err  out  1  invalid mem_sel for the access size.
REQ-019 result_out, reg_write_en_out, reg_write_addr_out, current_pc_addr_out  out  to MEM/WB.

Function
REQ-020 The FSM SHALL have states IDLE, REQ, DONE.
REQ-021 access = (mem_read_flag|mem_write_flag) & valid_sel.
- valid_sel: 0001/0010/0100/1000 (byte), 0011/1100 (half), 1111 (word).
REQ-022 IDLE, access=1:
- next state REQ.
- stall_request=1 combinationally.
REQ-023 IDLE, access=0:
- stall_request=0.
- result_out=result_in.
REQ-024 REQ:
- ram_req=1, stall_request=1.
- ram_addr, ram_we, ram_wdata stable until the ack cycle.
REQ-025 REQ, ram_ack=1:
- load data register captures extracted load data.
- next state DONE.
- Without ack, REQ holds indefinitely.
REQ-026 DONE:
- ram_req=0, stall_request=0.
- result_out = load data register for reads, result_in for writes.
- stall_next_stage=1 keeps DONE; otherwise next state IDLE.
REQ-027 Each instruction SHALL issue exactly one bus request.
- Minimum latency: arrival cycle plus 2 cycles (IDLE->REQ->DONE).
REQ-028 Load extraction:
- Shift selected lanes to bit 0.
- mem_sign_ext_flag=1: sign-extend from bit 7 (byte) or bit 15 (half); otherwise zero-extend.
- Word: unmodified.
REQ-029 Store lanes:
- byte: ram_wdata = {4{data[7:0]}}.
- half: ram_wdata = {2{data[15:0]}}.
- word: data as-is.
- ram_we = mem_sel during REQ, else 0000.
REQ-030 Invalid mem_sel with read or write flag:
- align_err=1 combinationally.
- no request, stall_request=0.
- result_out=result_in.
- reg_write_en_out forced 0 for reads.
REQ-031 Both read and write flags set SHALL be treated as write.
REQ-032 reg_write_en_out, reg_write_addr_out, current_pc_addr_out SHALL pass through combinationally in all states.

Reset
REQ-033 rst low SHALL immediately force:
- state IDLE, ram_req=0, ram_we=0000.
- load data register 0, stall_request=0, align_err=0.
REQ-034 Reset asserted in REQ SHALL abandon the transaction; no retry after release.

Verification
REQ-035 LB, addr 0x1003, sel 1000, sign_ext=1, rdata 0x80FFFFFF, ack after 3 REQ cycles -> ram_addr 0x1000; stall 5 cycles; DONE result_out 0xFFFFFF80.
REQ-036 SH, addr 0x2002, sel 1100, data 0x0000BEEF, ack immediate -> ram_we 1100, ram_wdata 0xBEEFBEEF, one ram_req cycle.
REQ-037 LHU, sel 0011, rdata 0x1234F00D, stall_next_stage high 2 cycles in DONE -> result_out 0x0000F00D held 3 cycles; single request.
REQ-038 LW, sel 0110 -> align_err=1, ram_req=0, stall_request=0, reg_write_en_out=0.
REQ-039 rst low mid-REQ -> ram_req drops the same cycle; after release, FSM in IDLE with no re-request until a new access.
REQ-040 ALU op (no flags), result_in 0xDEADBEEF -> result_out 0xDEADBEEF, stall_request=0, ram_req=0.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store unit: one bus request per access; IDLE->REQ->DONE, minimum 2 cycles after arrival.
// Stalls upstream while requesting; stall_next_stage holds DONE and its result.
module mem_access_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read_flag,
  input  logic                  mem_write_flag,
  input  logic                  mem_sign_ext_flag,
  input  logic [3:0]            mem_sel,
  input  logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] result_in,
  input  logic                  reg_write_en_in,
  input  logic [4:0]            reg_write_addr_in,
  input  logic [ADDR_WIDTH-1:0] current_pc_addr_in,
  input  logic                  stall_next_stage,
  output logic                  ram_req,
  output logic [3:0]            ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic                  ram_ack,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  stall_request,
  output logic                  align_err,
  output logic [DATA_WIDTH-1:0] result_out,
  output logic                  reg_write_en_out,
  output logic [4:0]            reg_write_addr_out,
  output logic [ADDR_WIDTH-1:0] current_pc_addr_out
);

  localparam int LANES = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_BAD} size_t;

  state_t                state, state_nxt;
  size_t                 sel_size, size_q;
  logic [1:0]            sel_off, off_q;
  logic                  sext_q, rd_q;
  logic [3:0]            we_q;
  logic [ADDR_WIDTH-1:0] addr_q, addr_aligned;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_lanes, load_q, load_ext, rdata_shifted;
  logic                  mem_op, is_read, access;

  always_comb begin
    sel_size = SZ_BAD;
    sel_off  = 2'd0;
    case (mem_sel)
      4'b0001: begin sel_size = SZ_BYTE; sel_off = 2'd0; end
      4'b0010: begin sel_size = SZ_BYTE; sel_off = 2'd1; end
      4'b0100: begin sel_size = SZ_BYTE; sel_off = 2'd2; end
      4'b1000: begin sel_size = SZ_BYTE; sel_off = 2'd3; end
      4'b0011: begin sel_size = SZ_HALF; sel_off = 2'd0; end
      4'b1100: begin sel_size = SZ_HALF; sel_off = 2'd2; end
      4'b1111: begin sel_size = SZ_WORD; sel_off = 2'd0; end
      default: begin sel_size = SZ_BAD;  sel_off = 2'd0; end
    endcase
  end

  // Read+write together is a store, so only a pure read counts as a load.
  assign mem_op       = mem_read_flag | mem_write_flag;
  assign is_read      = mem_read_flag & ~mem_write_flag;
  assign access       = rst & mem_op & (sel_size != SZ_BAD);
  assign align_err    = rst & mem_op & (sel_size == SZ_BAD);
  assign addr_aligned = {result_in[ADDR_WIDTH-1:2], 2'b00};

  always_comb begin
    wdata_lanes = mem_write_data;
    case (sel_size)
      SZ_BYTE: wdata_lanes = {LANES{mem_write_data[7:0]}};
      SZ_HALF: wdata_lanes = {(LANES/2){mem_write_data[15:0]}};
      default: wdata_lanes = mem_write_data;
    endcase
  end

  assign rdata_shifted = ram_rdata >> {off_q, 3'b000};

  always_comb begin
    load_ext = ram_rdata;
    case (size_q)
      SZ_BYTE: load_ext = {{(DATA_WIDTH-8){sext_q & rdata_shifted[7]}}, rdata_shifted[7:0]};
      SZ_HALF: load_ext = {{(DATA_WIDTH-16){sext_q & rdata_shifted[15]}}, rdata_shifted[15:0]};
      default: load_ext = ram_rdata;
    endcase
  end

  // Bus fields are captured at issue so they stay stable however long the ack takes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      we_q    <= 4'b0000;
      wdata_q <= '0;
      size_q  <= SZ_WORD;
      off_q   <= 2'd0;
      sext_q  <= 1'b0;
      rd_q    <= 1'b0;
      load_q  <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && access) begin
        addr_q  <= addr_aligned;
        we_q    <= mem_write_flag ? mem_sel : 4'b0000;
        wdata_q <= wdata_lanes;
        size_q  <= sel_size;
        off_q   <= sel_off;
        sext_q  <= mem_sign_ext_flag;
        rd_q    <= is_read;
      end
      if (state == REQ && ram_ack) begin
        load_q <= load_ext;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    ram_req       = 1'b0;
    stall_request = 1'b0;
    case (state)
      IDLE: begin
        stall_request = access;
        if (access) state_nxt = REQ;
      end
      REQ: begin
        ram_req       = 1'b1;
        stall_request = 1'b1;
        if (ram_ack) state_nxt = DONE;
      end
      DONE: begin
        if (!stall_next_stage) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ram_we    = (state == REQ) ? we_q : 4'b0000;
  assign ram_addr  = (state == IDLE) ? addr_aligned : addr_q;
  assign ram_wdata = (state == IDLE) ? wdata_lanes : wdata_q;

  assign result_out          = (state == DONE && rd_q) ? load_q : result_in;
  assign reg_write_en_out    = reg_write_en_in & ~(align_err & is_read);
  assign reg_write_addr_out  = reg_write_addr_in;
  assign current_pc_addr_out = current_pc_addr_in;

endmodule
